bin2rns_lut_1: RTL and testbench
================================

Name: bin2rns_lut_1

Overview:
Binary-to-RNS forward converter for the moduli set {3, 5, 7, 8} (M = 840, signed dynamic range -420..419).
- Takes a 32-bit two's-complement integer and produces four 3-bit residues, one per modulus.
- Registered, LUT-based; it is the front end feeding the RNS arithmetic datapath.

Parameters:
- WIDTH, 32, input word width (two's complement); the implementation is only required to support 32.
- M1, 3, modulus for out_mod_1 (fixed constant, not overridable in this revision).
- M2, 5, modulus for out_mod_2 (fixed).
- M3, 7, modulus for out_mod_3 (fixed).
- M4, 8, modulus for out_mod_4 (fixed).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- n  input  32  signed two's-complement binary operand.
- out_mod_1  output  3  n mod 3, range 0..2; bit 2 is always 0.
- out_mod_2  output  3  n mod 5, range 0..4.
- out_mod_3  output  3  n mod 7, range 0..6.
- out_mod_4  output  3  n mod 8, range 0..7; equals n[2:0].

Behaviour:
- Residue definition: out_mod_k = ((n interpreted as signed) mod Mk), always non-negative (mathematical mod).
  - Example: n = -1 -> (2, 4, 6, 7).
- Defined for every 32-bit input, not only -420..419:
  - No saturation and no error flag.
  - Out-of-range inputs alias per CRT: n and n ± 840 give identical residues.
- Latency is exactly one clock.
  - n sampled at rising edge t appears on all four outputs after edge t.
  - Outputs are held until the next edge.
  - New input is accepted every cycle; no handshake or valid signal.
- Reset: synchronous. While reset is high at a rising edge, all four outputs become 3'b000 regardless of n.
  - The first valid residue appears on the first edge with reset low.
  - Reset mid-stream discards the in-flight value; no other state exists.
- All four outputs are registered together, so they always correspond to the same input sample.
- Datapath: purely combinational residue computation feeding a single output register stage.
- Required structure (LUT-based):
  - Split n into eight 4-bit nibbles.
  - For each modulus, a per-nibble-position ROM gives (nibble * 16^k) mod Mk.
  - The top nibble uses signed weight, i.e. bit 31 weighs -2^31; equivalently its LUT entries are pre-reduced for a negative MSB.
  - Sum the eight partial residues (max 8*(Mk-1) = 56, fits 6 bits).
  - Final reduction by a small LUT or compare-subtract to 0..Mk-1.
- Mod 8: taken directly from n[2:0], no LUT (power-of-two modulus).
- No X propagation: all ROM entries are fully defined constants.

Decomposition:
- Shared package rns_pkg holds:
  - moduli constants RNS_M1..RNS_M4 = 3, 5, 7, 8 and RNS_M = 840;
  - residue width constant RES_W = 3;
  - constant functions generating the nibble-weight ROM contents.
- One natural sub-module: rns_residue_lut, parameterised by modulus.
  - Combinational; 32-bit in, 3-bit residue out.
  - Instantiated three times, for moduli 3, 5, 7.
- The top level holds the mod-8 slice and the output register stage.

Test Plan:
- Reset high for 1+ cycles with n = 123 -> all outputs 0. After release, one cycle later -> (0, 3, 4, 3).
- Boundaries, each one cycle after input:
  - n = -420 -> (0, 0, 0, 4)
  - n = 419 -> (2, 4, 6, 3)
  - n = 0 -> (0, 0, 0, 0)
  - n = -1 -> (2, 4, 6, 7)
- Exhaustive sweep n = -420..419, one value per clock:
  - each output equals the golden non-negative mod, one cycle delayed;
  - all 840 residue tuples are distinct (CRT uniqueness).
- Out-of-range aliasing: n = 500 and n = -340 -> both (2, 0, 3, 4); n = 32'h7FFFFFFF -> (1, 2, 1, 7); n = 32'h80000000 -> (1, 2, 5, 0).
- Reset asserted mid-sweep for one cycle -> outputs 0 that cycle, then resume correct residues with 1-cycle latency and no stale value.

Source files
------------

// File: rtl/rns_pkg.sv
// Shared constants and ROM generators for the {3,5,7,8} residue number system.
// Latency: n/a (compile-time constants and constant functions only).
// Backpressure: n/a.
package rns_pkg;

    localparam int RNS_M1 = 3;
    localparam int RNS_M2 = 5;
    localparam int RNS_M3 = 7;
    localparam int RNS_M4 = 8;
    localparam int RNS_M  = RNS_M1 * RNS_M2 * RNS_M3 * RNS_M4;
    localparam int RES_W  = 3;

    // Residue of (nibble * 16^pos) mod m. Position 7 holds the sign bit, so its
    // nibble is read as a signed value (-8..7) before weighting.
    function automatic logic [RES_W-1:0] nib_res(input int m, input int pos, input int nib);
        int w;
        int v;
        w = 1;
        for (int i = 0; i < pos; i++) begin
            w = (w * 16) % m;
        end
        v = (pos == 7 && nib >= 8) ? nib - 16 : nib;
        v = ((v * w) % m + m) % m;
        return RES_W'(v);
    endfunction

    // Sixteen 3-bit entries for one nibble position, entry v at bits [3v +: 3].
    function automatic logic [16*RES_W-1:0] nib_rom(input int m, input int pos);
        logic [16*RES_W-1:0] r;
        r = '0;
        for (int v = 0; v < 16; v++) begin
            r[v*RES_W +: RES_W] = nib_res(m, pos, v);
        end
        return r;
    endfunction

    // Final reduction table: sum of eight partial residues (0..63) mod m.
    function automatic logic [64*RES_W-1:0] fold_rom(input int m);
        logic [64*RES_W-1:0] r;
        r = '0;
        for (int s = 0; s < 64; s++) begin
            r[s*RES_W +: RES_W] = RES_W'(s % m);
        end
        return r;
    endfunction

endpackage

// File: rtl/rns_residue_lut.sv
// Combinational n mod MOD for a 32-bit two's-complement n via per-nibble ROMs.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output tracks input continuously.
module rns_residue_lut
    import rns_pkg::*;
#(
    parameter int MOD = 3
) (
    input  logic [31:0]      n,
    output logic [RES_W-1:0] res
);

    localparam logic [64*RES_W-1:0] FOLD = fold_rom(MOD);

    logic [RES_W-1:0] part [8];
    logic [5:0]       sum;

    for (genvar p = 0; p < 8; p++) begin : g_nib
        localparam logic [16*RES_W-1:0] ROM = nib_rom(MOD, p);
        logic [3:0] nib;
        assign nib     = n[p*4 +: 4];
        assign part[p] = ROM[nib*RES_W +: RES_W];
    end

    // Sum partial residues; eight terms of at most 6 each stay below 64.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'b000, part[i]};
        end
    end

    assign res = FOLD[sum*RES_W +: RES_W];

endmodule

// File: rtl/bin2rns_lut_1.sv
// Binary to RNS {3,5,7,8} forward converter with one output register stage.
// Latency: 1 cycle from n to all four residues; synchronous reset clears them.
// Backpressure: none; a new operand is accepted every cycle.
module bin2rns_lut_1
    import rns_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] n,
    output logic [2:0]       out_mod_1,
    output logic [2:0]       out_mod_2,
    output logic [2:0]       out_mod_3,
    output logic [2:0]       out_mod_4
);

    logic [RES_W-1:0] res_1, res_2, res_3;
    logic [RES_W-1:0] out_mod_1_d, out_mod_2_d, out_mod_3_d, out_mod_4_d;
    logic [RES_W-1:0] out_mod_1_q, out_mod_2_q, out_mod_3_q, out_mod_4_q;

    rns_residue_lut #(.MOD(RNS_M1)) u_res_1 (.n(n), .res(res_1));
    rns_residue_lut #(.MOD(RNS_M2)) u_res_2 (.n(n), .res(res_2));
    rns_residue_lut #(.MOD(RNS_M3)) u_res_3 (.n(n), .res(res_3));

    // Next residues; mod 8 is just the low three bits in two's complement.
    always_comb begin
        out_mod_1_d = res_1;
        out_mod_2_d = res_2;
        out_mod_3_d = res_3;
        out_mod_4_d = n[2:0];
        if (reset) begin
            out_mod_1_d = '0;
            out_mod_2_d = '0;
            out_mod_3_d = '0;
            out_mod_4_d = '0;
        end
    end

    // Register all four residues together so they always belong to one sample.
    always_ff @(posedge clk) begin
        out_mod_1_q <= out_mod_1_d;
        out_mod_2_q <= out_mod_2_d;
        out_mod_3_q <= out_mod_3_d;
        out_mod_4_q <= out_mod_4_d;
    end

    assign out_mod_1 = out_mod_1_q;
    assign out_mod_2 = out_mod_2_q;
    assign out_mod_3 = out_mod_3_q;
    assign out_mod_4 = out_mod_4_q;

endmodule

// File: tb/tb_bin2rns_lut_1.sv
module tb_bin2rns_lut_1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] n;
    logic [2:0]  out_mod_1, out_mod_2, out_mod_3, out_mod_4;

    int checks = 0;
    int errors = 0;

    bin2rns_lut_1 dut (
        .clk       (clk),
        .reset     (reset),
        .n         (n),
        .out_mod_1 (out_mod_1),
        .out_mod_2 (out_mod_2),
        .out_mod_3 (out_mod_3),
        .out_mod_4 (out_mod_4)
    );

    always #5 clk = ~clk;

    // Mathematical (non-negative) modulo of a signed value.
    function automatic int gmod(input longint v, input int m);
        longint r;
        r = v % m;
        if (r < 0) r = r + m;
        return int'(r);
    endfunction

    // Expected tuple {mod3, mod5, mod7, mod8} packed as four 3-bit fields.
    function automatic logic [11:0] model(input logic [31:0] x);
        longint s;
        s = longint'($signed(x));
        return {3'(gmod(s, 3)), 3'(gmod(s, 5)), 3'(gmod(s, 7)), 3'(gmod(s, 8))};
    endfunction

    function automatic logic [11:0] obs();
        return {out_mod_1, out_mod_2, out_mod_3, out_mod_4};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got (%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)", tag,
                   got[11:9], got[8:6], got[5:3], got[2:0],
                   exp[11:9], exp[8:6], exp[5:3], exp[2:0]);
        end
    endtask

    // Apply one operand, let one edge pass, sample 1 time unit later.
    task automatic step(input logic [31:0] v);
        n = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] tup(input int a, input int b, input int c, input int d);
        return {3'(a), 3'(b), 3'(c), 3'(d)};
    endfunction

    bit          seen [4096];
    int          distinct;
    logic [31:0] r;
    logic [11:0] t;

    initial begin
        reset = 1'b1;
        n     = 32'd123;
        @(posedge clk); @(posedge clk); #1;
        check("reset_zero", obs(), 12'd0);

        reset = 1'b0;
        step(32'd123);
        check("post_reset_123", obs(), tup(0, 3, 4, 3));

        step(-32'sd420);        check("n_m420",  obs(), tup(0, 0, 0, 4));
        step(32'd419);          check("n_419",   obs(), tup(2, 4, 6, 3));
        step(32'd0);            check("n_0",     obs(), tup(0, 0, 0, 0));
        step(32'hFFFF_FFFF);    check("n_m1",    obs(), tup(2, 4, 6, 7));
        step(32'd500);          check("n_500",   obs(), tup(2, 0, 3, 4));
        step(-32'sd340);        check("n_m340",  obs(), tup(2, 0, 3, 4));
        step(32'h7FFF_FFFF);    check("n_max",   obs(), tup(1, 2, 1, 7));
        step(32'h8000_0000);    check("n_min",   obs(), tup(1, 2, 5, 0));

        // Exhaustive sweep of the signed dynamic range, with a one-cycle reset pulse.
        distinct = 0;
        for (int i = -420; i <= 419; i++) begin
            if (i == 0) begin
                reset = 1'b1;
                step(32'(i + 7));
                check("mid_reset", obs(), 12'd0);
                reset = 1'b0;
            end
            step(32'(i));
            t = obs();
            check($sformatf("sweep_%0d", i), t, model(32'(i)));
            if (!seen[t]) distinct++;
            seen[t] = 1'b1;
        end
        checks++;
        assert (distinct == 840) else begin
            errors++;
            $error("FAIL crt_unique: got %0d distinct tuples expected 840", distinct);
        end

        // Random full-width operands, plus aliasing against n + 840.
        for (int k = 0; k < 200; k++) begin
            r = $urandom;
            step(r);
            check($sformatf("rand_%08h", r), obs(), model(r));
            if (k < 40) begin
                t = obs();
                step(r + 32'd840);
                if ($signed(r) < $signed(32'h7FFF_FFFF - 32'd840))
                    check($sformatf("alias_%08h", r), obs(), t);
                else
                    check($sformatf("wrap_%08h", r), obs(), model(r + 32'd840));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
